// File: rtl/note_rec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_rec_pkg
//  Description : Shared constants, record field layout helpers and a
//                saturating subtract used by the note event recorder.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_rec_pkg;

    // master_state encoding that means "recording"
    localparam logic [1:0] MS_RECORD = 2'b01;

    // Record layout, MSB first: {is_rest, note, start_beat, duration}
    function automatic int rec_width(input int note_w, input int time_w, input int dur_w);
        return 1 + note_w + time_w + dur_w;
    endfunction

    function automatic int dur_lsb();
        return 0;
    endfunction

    function automatic int start_lsb(input int dur_w);
        return dur_w;
    endfunction

    function automatic int note_lsb(input int time_w, input int dur_w);
        return time_w + dur_w;
    endfunction

    function automatic int rest_bit(input int note_w, input int time_w, input int dur_w);
        return note_w + time_w + dur_w;
    endfunction

    // a - b, clamped at zero
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_channel_capture.sv
`default_nettype none
// ============================================================================
//  Module      : note_channel_capture
//  Description : One capture channel: edge detect on a gated key level,
//                start/note latch, clamped duration and a single pending
//                record slot with drop indication on collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_channel_capture
    import note_rec_pkg::*;
#(
    parameter int NOTE_W    = 6,
    parameter int TIME_W    = 12,
    parameter int DUR_W     = 8,
    parameter bit IS_REST   = 1'b0,
    parameter bit DROP_ZERO = 1'b0,
    localparam int DATA_W   = rec_width(NOTE_W, TIME_W, DUR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_key,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [TIME_W-1:0] i_time,
    input  logic              i_grant,
    output logic              o_pending,
    output logic              o_drop,
    output logic [DATA_W-1:0] o_payload
);

    localparam logic [31:0] DUR_MAX   = 32'((64'd1 << DUR_W) - 64'd1);
    localparam int          REST_BIT  = rest_bit(NOTE_W, TIME_W, DUR_W);
    localparam int          NOTE_LSB  = note_lsb(TIME_W, DUR_W);
    localparam int          START_LSB = start_lsb(DUR_W);
    localparam int          DUR_LSB   = dur_lsb();

    logic              key_q,     key_d;
    logic [NOTE_W-1:0] note_q,    note_d;
    logic [TIME_W-1:0] start_q,   start_d;
    logic              pend_q,    pend_d;
    logic [NOTE_W-1:0] p_note_q,  p_note_d;
    logic [TIME_W-1:0] p_start_q, p_start_d;
    logic [DUR_W-1:0]  p_dur_q,   p_dur_d;

    logic              w_rise;
    logic              w_fall;
    logic [31:0]       w_diff;
    logic [DUR_W-1:0]  w_dur;

    // Edge detect, latch on press, load pending slot on release
    always_comb begin
        key_d     = i_key;
        note_d    = note_q;
        start_d   = start_q;
        pend_d    = pend_q;
        p_note_d  = p_note_q;
        p_start_d = p_start_q;
        p_dur_d   = p_dur_q;
        o_drop    = 1'b0;

        w_rise = i_key & ~key_q;
        w_fall = ~i_key & key_q;
        w_diff = sat_sub(32'(i_time), 32'(start_q));
        w_dur  = (w_diff > DUR_MAX) ? DUR_MAX[DUR_W-1:0] : w_diff[DUR_W-1:0];

        if (i_clear) begin
            pend_d  = 1'b0;
            note_d  = '0;
            start_d = '0;
        end else if (i_grant) begin
            pend_d  = 1'b0;
        end

        if (w_rise) begin
            note_d  = i_note;
            start_d = i_time;
        end

        if (w_fall) begin
            if (DROP_ZERO && (w_dur == '0)) begin
                // zero-length record is silently discarded
                pend_d = pend_d;
            end else if (pend_q && !i_grant && !i_clear) begin
                // slot still occupied: this record is lost
                o_drop = 1'b1;
            end else begin
                // a grant in the same cycle frees the slot for this record
                pend_d    = 1'b1;
                p_note_d  = note_q;
                p_start_d = start_q;
                p_dur_d   = w_dur;
            end
        end
    end

    // Record assembly from the pending slot
    always_comb begin
        o_pending                        = pend_q;
        o_payload                        = '0;
        o_payload[REST_BIT]              = IS_REST;
        o_payload[NOTE_LSB  +: NOTE_W]   = p_note_q;
        o_payload[START_LSB +: TIME_W]   = p_start_q;
        o_payload[DUR_LSB   +: DUR_W]    = p_dur_q;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q     <= 1'b0;
            note_q    <= '0;
            start_q   <= '0;
            pend_q    <= 1'b0;
            p_note_q  <= '0;
            p_start_q <= '0;
            p_dur_q   <= '0;
        end else begin
            key_q     <= key_d;
            note_q    <= note_d;
            start_q   <= start_d;
            pend_q    <= pend_d;
            p_note_q  <= p_note_d;
            p_start_q <= p_start_d;
            p_dur_q   <= p_dur_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_event_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : note_event_recorder
//  Description : Records timestamped note and rest events from N_CH key
//                channels into song RAM. Releases are buffered per channel
//                and written one per cycle through a round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_event_recorder
    import note_rec_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int NOTE_W   = 6,
    parameter int ADDR_W   = 7,
    parameter int TIME_W   = 12,
    parameter int DUR_W    = 8,
    localparam int DATA_W  = rec_width(NOTE_W, TIME_W, DUR_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat,
    input  logic [1:0]             master_state,
    input  logic [N_CH-1:0]        switches,
    input  logic [N_CH*NOTE_W-1:0] notes,
    output logic                   start_recording,
    output logic                   finished_recording,
    output logic                   overflow,
    output logic                   write_enable,
    output logic [ADDR_W-1:0]      write_address,
    output logic [DATA_W-1:0]      write_payload
);

    localparam int N_SLOT = N_CH + 1;
    localparam int IDX_W  = $clog2(N_SLOT);

    logic                rec_q,        rec_d;
    logic [TIME_W-1:0]   time_now_q,   time_now_d;
    logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
    logic [IDX_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic                start_rec_q,  start_rec_d;
    logic                finished_q,   finished_d;
    logic                overflow_q,   overflow_d;
    logic                wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0]   wr_out_addr_q, wr_out_addr_d;
    logic [DATA_W-1:0]   wr_payload_q, wr_payload_d;

    logic                w_rec;
    logic                w_start;
    logic [TIME_W-1:0]   w_time_cur;
    logic [N_SLOT-1:0]   w_key;
    logic [N_SLOT-1:0]   w_pending;
    logic [N_SLOT-1:0]   w_drop;
    logic [N_SLOT-1:0]   w_grant;
    logic [DATA_W-1:0]   w_payload [N_SLOT];
    logic                w_gnt_found;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [IDX_W:0]      w_scan;

    assign w_rec      = (master_state == MS_RECORD);
    assign w_start    = w_rec & ~rec_q;
    // the start cycle already sees a cleared timestamp
    assign w_time_cur = w_start ? '0 : time_now_q;

    // Key channels: gating by rec turns exit from RECORD into a release
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_key[i] = w_rec & switches[i];

            note_channel_capture #(
                .NOTE_W    (NOTE_W),
                .TIME_W    (TIME_W),
                .DUR_W     (DUR_W),
                .IS_REST   (1'b0),
                .DROP_ZERO (1'b0)
            ) u_cap (
                .clk       (clk),
                .reset     (reset),
                .i_clear   (w_start),
                .i_key     (w_key[i]),
                .i_note    (notes[i*NOTE_W +: NOTE_W]),
                .i_time    (w_time_cur),
                .i_grant   (w_grant[i]),
                .o_pending (w_pending[i]),
                .o_drop    (w_drop[i]),
                .o_payload (w_payload[i])
            );
        end
    endgenerate

    // Rest channel: active while recording with no key held
    assign w_key[N_CH] = w_rec & ~(|switches);

    note_channel_capture #(
        .NOTE_W    (NOTE_W),
        .TIME_W    (TIME_W),
        .DUR_W     (DUR_W),
        .IS_REST   (1'b1),
        .DROP_ZERO (1'b1)
    ) u_rest (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start),
        .i_key     (w_key[N_CH]),
        .i_note    ('0),
        .i_time    (w_time_cur),
        .i_grant   (w_grant[N_CH]),
        .o_pending (w_pending[N_CH]),
        .o_drop    (w_drop[N_CH]),
        .o_payload (w_payload[N_CH])
    );

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < N_SLOT; k++) begin
            w_scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(N_SLOT)) begin
                w_scan = w_scan - (IDX_W+1)'(N_SLOT);
            end
            if (!w_gnt_found && w_pending[w_scan[IDX_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan[IDX_W-1:0];
            end
        end
        // pending state is being wiped on a new recording
        if (w_start) begin
            w_gnt_found = 1'b0;
        end
        w_grant = '0;
        if (w_gnt_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // Timestamp, address, status and write-port next state
    always_comb begin
        rec_d         = w_rec;
        start_rec_d   = w_start;
        time_now_d    = time_now_q;
        wr_addr_d     = wr_addr_q;
        rr_ptr_d      = rr_ptr_q;
        finished_d    = finished_q;
        overflow_d    = overflow_q | (|w_drop);
        wr_en_d       = 1'b0;
        wr_out_addr_d = wr_out_addr_q;
        wr_payload_d  = wr_payload_q;

        if (w_start) begin
            time_now_d = '0;
            wr_addr_d  = '0;
            finished_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (w_rec && beat && (time_now_q != {TIME_W{1'b1}})) begin
                time_now_d = time_now_q + TIME_W'(1);
            end
            if (w_gnt_found) begin
                rr_ptr_d = (w_gnt_idx == IDX_W'(N_SLOT-1)) ? '0 : (w_gnt_idx + IDX_W'(1));
                if (finished_q) begin
                    // RAM full: the granted record is consumed but lost
                    overflow_d = 1'b1;
                end else begin
                    wr_en_d       = 1'b1;
                    wr_out_addr_d = wr_addr_q;
                    wr_payload_d  = w_payload[w_gnt_idx];
                    if (wr_addr_q == {ADDR_W{1'b1}}) begin
                        finished_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // Top-level state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec_q         <= 1'b0;
            start_rec_q   <= 1'b0;
            time_now_q    <= '0;
            wr_addr_q     <= '0;
            rr_ptr_q      <= '0;
            finished_q    <= 1'b0;
            overflow_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_out_addr_q <= '0;
            wr_payload_q  <= '0;
        end else begin
            rec_q         <= rec_d;
            start_rec_q   <= start_rec_d;
            time_now_q    <= time_now_d;
            wr_addr_q     <= wr_addr_d;
            rr_ptr_q      <= rr_ptr_d;
            finished_q    <= finished_d;
            overflow_q    <= overflow_d;
            wr_en_q       <= wr_en_d;
            wr_out_addr_q <= wr_out_addr_d;
            wr_payload_q  <= wr_payload_d;
        end
    end

    assign start_recording    = start_rec_q;
    assign finished_recording = finished_q;
    assign overflow           = overflow_q;
    assign write_enable       = wr_en_q;
    assign write_address      = wr_out_addr_q;
    assign write_payload      = wr_payload_q;

endmodule
`default_nettype wire

// File: tb/tb_note_event_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_event_recorder
//  Description : Directed self-checking bench for note_event_recorder with
//                default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_event_recorder;

    localparam int N_CH   = 8;
    localparam int NOTE_W = 6;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 27;

    logic                   clk;
    logic                   reset;
    logic                   beat;
    logic [1:0]             master_state;
    logic [N_CH-1:0]        switches;
    logic [N_CH*NOTE_W-1:0] notes;
    logic                   start_recording;
    logic                   finished_recording;
    logic                   overflow;
    logic                   write_enable;
    logic [ADDR_W-1:0]      write_address;
    logic [DATA_W-1:0]      write_payload;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_cnt = 0;
    int wcount = 0;
    int wc0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [DATA_W-1:0] q_data [$];
    int                q_cyc  [$];

    note_event_recorder u_dut (
        .clk                (clk),
        .reset              (reset),
        .beat               (beat),
        .master_state       (master_state),
        .switches           (switches),
        .notes              (notes),
        .start_recording    (start_recording),
        .finished_recording (finished_recording),
        .overflow           (overflow),
        .write_enable       (write_enable),
        .write_address      (write_address),
        .write_payload      (write_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    // RAM write log
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            q_addr.push_back(write_address);
            q_data.push_back(write_payload);
            q_cyc.push_back(cyc_cnt);
            wcount++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic r, input logic [5:0] n,
                                             input logic [11:0] s, input logic [7:0] d);
        return {r, n, s, d};
    endfunction

    task automatic check_rec(input string tag, input int idx,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [63:0] got;
        got = (idx < q_data.size()) ? {30'd0, q_addr[idx], q_data[idx]} : {64{1'b1}};
        check(tag, got, {30'd0, a, d});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beats(input int n);
        beat = 1'b1;
        cyc(n);
        beat = 1'b0;
    endtask

    task automatic set_note(input int ch, input logic [5:0] v);
        notes[ch*NOTE_W +: NOTE_W] = v;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; beat = 1'b0; master_state = 2'b00;
        switches = '0; notes = '0;
        #1 reset = 1'b0;
        cyc(2);
        check("rst we",       write_enable,       0);
        check("rst addr",     write_address,      0);
        check("rst payload",  write_payload,      0);
        check("rst finished", finished_recording, 0);
        check("rst overflow", overflow,           0);
        check("rst start",    start_recording,    0);
        reset = 1'b1;
        cyc(2);

        // rest of 2 beats then ch0 note 12 from beat 2 to 5
        clear_log();
        master_state = 2'b01; cyc(1);
        check("A start pulse", start_recording, 1);
        beats(2);
        set_note(0, 6'd12); switches = 8'h01; cyc(1);
        beats(3);
        switches = 8'h00; cyc(1);
        master_state = 2'b00; cyc(4);
        check("A count", q_data.size(), 2);
        check_rec("A rec0", 0, 7'd0, mk(1'b1, 6'd0, 12'd0, 8'd2));
        check_rec("A rec1", 1, 7'd1, mk(1'b0, 6'd12, 12'd2, 8'd3));

        // simultaneous release of ch1, ch3, ch7
        clear_log();
        master_state = 2'b01; cyc(1);
        set_note(1, 6'd5); set_note(3, 6'd9); set_note(7, 6'd33);
        switches = 8'b1000_1010; cyc(1);
        check("B start one cycle", start_recording, 0);
        beats(1);
        switches = 8'h00; cyc(5);
        master_state = 2'b00; cyc(3);
        check("B count", q_data.size(), 3);
        check_rec("B rec0", 0, 7'd0, mk(1'b0, 6'd5,  12'd0, 8'd1));
        check_rec("B rec1", 1, 7'd1, mk(1'b0, 6'd9,  12'd0, 8'd1));
        check_rec("B rec2", 2, 7'd2, mk(1'b0, 6'd33, 12'd0, 8'd1));
        if (q_cyc.size() >= 3) begin
            check("B back to back 01", q_cyc[1] - q_cyc[0], 1);
            check("B back to back 12", q_cyc[2] - q_cyc[1], 1);
        end else begin
            check("B pulses", q_cyc.size(), 3);
        end

        // ch5 re-released while its first record waits behind ch0..ch4
        clear_log();
        master_state = 2'b01; cyc(1);
        for (int i = 0; i < 6; i++) set_note(i, 6'(i + 1));
        switches = 8'h3F; cyc(1);
        switches = 8'h00; cyc(1);
        switches = 8'h20; cyc(1);
        switches = 8'h00; cyc(1);
        check("D overflow set", overflow, 1);
        cyc(6);
        master_state = 2'b00; cyc(3);
        check("D count", q_data.size(), 6);
        check_rec("D ch5 rec", 5, 7'd5, mk(1'b0, 6'd6, 12'd0, 8'd0));
        check("D overflow sticky", overflow, 1);

        // exit flush of a held channel, then long hold saturating duration
        clear_log();
        master_state = 2'b01; cyc(1);
        check("E overflow cleared", overflow, 0);
        beats(4);
        set_note(2, 6'd21); switches = 8'h04; cyc(1);
        beats(6);
        master_state = 2'b00; cyc(4);
        switches = 8'h00; cyc(1);
        check("E count", q_data.size(), 2);
        check_rec("E rest", 0, 7'd0, mk(1'b1, 6'd0, 12'd0, 8'd4));
        check_rec("E flush", 1, 7'd1, mk(1'b0, 6'd21, 12'd4, 8'd6));
        clear_log();
        master_state = 2'b01; cyc(1);
        switches = 8'h04; cyc(1);
        beats(300);
        switches = 8'h00; cyc(1);
        master_state = 2'b00; cyc(3);
        check("E sat count", q_data.size(), 1);
        check_rec("E sat rec", 0, 7'd0, mk(1'b0, 6'd21, 12'd0, 8'd255));

        // fill all 128 addresses, then one more release
        clear_log();
        set_note(0, 6'd7);
        master_state = 2'b01; cyc(1);
        for (int i = 0; i < 128; i++) begin
            switches = 8'h01; cyc(1);
            switches = 8'h00; cyc(1);
        end
        cyc(3);
        check("F count", q_data.size(), 128);
        check("F finished", finished_recording, 1);
        check("F no overflow yet", overflow, 0);
        check_rec("F last", 127, 7'd127, mk(1'b0, 6'd7, 12'd0, 8'd0));
        switches = 8'h01; cyc(1);
        switches = 8'h00; cyc(3);
        check("F no write when full", q_data.size(), 128);
        check("F overflow", overflow, 1);
        check("F finished holds", finished_recording, 1);

        // reset while three records are pending
        master_state = 2'b00; cyc(2);
        master_state = 2'b01; cyc(1);
        switches = 8'h0E; cyc(1);
        switches = 8'h00; cyc(1);
        reset = 1'b0; #1;
        wc0 = wcount;
        check("R we",       write_enable,       0);
        check("R addr",     write_address,      0);
        check("R payload",  write_payload,      0);
        check("R finished", finished_recording, 0);
        check("R overflow", overflow,           0);
        master_state = 2'b00; cyc(2);
        reset = 1'b1; cyc(10);
        check("R no writes after reset", wcount - wc0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_event_recorder.md
Name: note_event_recorder

Overview:
Parametrised successor to the single-hold-writer recorder: captures up to N_CH keyboard channels plus a rest channel while recording and writes timestamped note records to RAM. Each record is {is_rest, note, start_beat, duration}, so playback no longer depends on address order for timing. Simultaneous releases are buffered and serialised by a round-robin arbiter instead of being lost. Sits between the note/switch front end and the song RAM, under lip_synth_master control.

Parameters:
N_CH, 8, number of note channels (1..16)
NOTE_W, 6, note code width per channel
ADDR_W, 7, RAM address width; depth = 2^ADDR_W records
TIME_W, 12, beat timestamp width
DUR_W, 8, duration field width in beats
DATA_W, 1+NOTE_W+TIME_W+DUR_W, derived localparam, not overridable

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
beat  in  1  one-cycle beat strobe
master_state  in  2  2'b01 = RECORD; any other value = not recording
switches  in  N_CH  per-channel key-held level
notes  in  N_CH*NOTE_W  channel i note = notes[i*NOTE_W +: NOTE_W]
start_recording  out  1  one-cycle pulse on entry to RECORD
finished_recording  out  1  level: RAM full
overflow  out  1  sticky: at least one record dropped
write_enable  out  1  one-cycle write strobe
write_address  out  ADDR_W  RAM address
write_payload  out  DATA_W  {is_rest, note, start_beat, duration}, MSB first

Behaviour:
- Reset (reset=0, async): all outputs 0; time, address, pending, capture and edge registers cleared.
- rec = (master_state==2'b01). start_recording is high for one cycle when rec was 0 on the previous cycle and is 1 on the current cycle. The same cycle clears time_now, wr_addr, overflow, finished_recording and all channel state.
- time_now: increments on beat while rec; saturates at 2^TIME_W-1.
- Channel i, edges sampled against a registered copy of switches, only while rec:
  - Rising edge latches note_i and start_i = time_now.
  - Falling edge sets pending_i with duration = min(time_now - start_i, 2^DUR_W-1). A press and release inside the same beat gives duration 0.
  - If pending_i is already set at a falling edge, the new record is dropped and overflow is set.
- Rest channel (index N_CH):
  - Active while rec and all switches are 0.
  - Start is latched when it becomes active. This includes the start_recording cycle when all switches are 0.
  - On the cycle any switch rises, it pends a record with is_rest=1 and note=0, but only if duration is at least 1. Zero-length rests are discarded.
- Exit from RECORD (rec 1->0): in that cycle every held channel and an active rest are force-released, producing pending records as if a falling edge had occurred. Flushing continues after exit until all pending flags are clear.
- Arbiter:
  - Round-robin over the N_CH+1 pending flags. Priority starts at the index after the last grant; after reset the search starts at 0.
  - At most one grant per cycle.
  - The grant registers the payload and wr_addr onto the outputs and pulses write_enable for 1 cycle, then clears that pending flag and increments wr_addr.
- Latency: falling edge sampled at edge k -> pending set at k -> write_enable high in the cycle after edge k+1 if uncontended. Worst case is N_CH+1 cycles later.
- Full:
  - After write 2^ADDR_W-1 completes, finished_recording goes to 1 and stays there until reset or the next start_recording. wr_addr does not wrap.
  - While full, grants still clear pending flags but write_enable stays 0 and overflow is set.
- Pending flag clear versus new falling edge on the same channel in the same cycle: the grant wins and the new record is loaded into the freed slot. It is not dropped.
- write_address and write_payload hold their last values between strobes.

Decomposition:
- Package note_rec_pkg:
  - MS_RECORD = 2'b01.
  - Record field offset and width localparam functions of NOTE_W, TIME_W and DUR_W.
  - A saturating subtract function.
- Sub-module note_channel_capture is instantiated N_CH+1 times; the rest instance has its note tied to 0 and is_rest=1. It contains:
  - edge detect;
  - start/note latch;
  - duration calculation;
  - the pending slot with its drop indication.
- The arbiter, time and address counters, and output register stay in the top module.

Test Plan:
- Reset mid-record with 3 channels pending -> all outputs 0 at once; no write_enable after reset deasserts.
- RECORD entered, 2 beats of silence, ch0 held note 6'd12 from beat 2 to beat 5 -> addr0 = {1,0,0,2}, addr1 = {0,12,2,3}.
- ch1, ch3 and ch7 released in the same cycle -> 3 consecutive write_enable pulses in order 1,3,7, with addresses 0,1,2.
- Default ADDR_W, fill 128 records, release one more -> finished_recording=1, write_enable stays 0, overflow=1.
- Leave RECORD with ch2 held since beat 4, time_now=10 -> flush record {0,note2,4,6}. Hold for 300 beats with DUR_W=8 -> duration saturates at 255.
- Release ch5, then re-press and release ch5 before it is granted, with the arbiter blocked by higher-priority pends -> second record dropped, overflow=1.
